// File: rtl/tart_corr_pkg.sv
// Shared constants for the correlator back end: default array geometry,
// partial-sum and accumulator widths, and a counter-width helper.
package tart_corr_pkg;

    localparam int CORES   = 18;
    localparam int TRATE   = 30;
    localparam int TOTAL   = CORES * TRATE;
    localparam int SBITS   = 7;
    localparam int ACCUM   = 36;
    localparam int NBLOCKS = 4096;

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W = width_of(TOTAL);
    localparam int BLK_W  = width_of(NBLOCKS);

endpackage

// File: rtl/partial_sum_accumulator_if.sv
// Partial-sum input stream and accumulated-visibility output stream.
// master: upstream/consumer side; slave: the accumulator.
interface partial_sum_accumulator_if #(
    parameter int IN_W  = tart_corr_pkg::SBITS,
    parameter int OUT_W = tart_corr_pkg::ACCUM
);

    logic             valid_i;
    logic             first_i;
    logic [IN_W-1:0]  revis_i;
    logic [IN_W-1:0]  imvis_i;

    logic             valid_o;
    logic             last_o;
    logic [OUT_W-1:0] revis_o;
    logic [OUT_W-1:0] imvis_o;
    logic             frame_o;
    logic             sync_err_o;

    modport master (
        output valid_i, first_i, revis_i, imvis_i,
        input  valid_o, last_o, revis_o, imvis_o,
        input  frame_o, sync_err_o
    );

    modport slave (
        input  valid_i, first_i, revis_i, imvis_i,
        output valid_o, last_o, revis_o, imvis_o,
        output frame_o, sync_err_o
    );

endinterface

// File: rtl/acc_sram.sv
// Simple dual-port accumulator store: one write port, one read port,
// synchronous read with one cycle of latency. Contents are never reset.
module acc_sram #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 72
) (
    input  logic          vis_clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge vis_clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates NBLOCKS blocks of signed partial-sum visibilities per point.
// Ports: vis_clock, reset_n (sync, active-low), ps_if (slave stream bundle).
module partial_sum_accumulator #(
    parameter int CORES   = tart_corr_pkg::CORES,
    parameter int TRATE   = tart_corr_pkg::TRATE,
    parameter int SBITS   = tart_corr_pkg::SBITS,
    parameter int ACCUM   = tart_corr_pkg::ACCUM,
    parameter int NBLOCKS = tart_corr_pkg::NBLOCKS
) (
    input  logic vis_clock,
    input  logic reset_n,
    partial_sum_accumulator_if.slave ps_if
);

    import tart_corr_pkg::*;

    localparam int TOTAL = CORES * TRATE;
    localparam int AW    = width_of(TOTAL);
    localparam int BW    = width_of(NBLOCKS);

    localparam logic [AW-1:0] ADDR_LAST = AW'(TOTAL - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(NBLOCKS - 1);

    logic [AW-1:0]      addr_q, addr_d, beat_addr;
    logic [BW-1:0]      blk_q, blk_d, beat_blk;
    logic               sync_err_q, sync_err_d;

    logic               v0_q, z0_q, e0_q;
    logic [AW-1:0]      a0_q;
    logic [ACCUM-1:0]   re0_q, im0_q;

    logic               vo_q, lo_q, fr_q;
    logic [ACCUM-1:0]   reo_q, imo_q;

    logic [ACCUM-1:0]   re_sx, im_sx;
    logic [2*ACCUM-1:0] rdata;
    logic [ACCUM-1:0]   rd_re, rd_im, sum_re, sum_im;
    logic               fire, we;

    assign re_sx = {{(ACCUM-SBITS){ps_if.revis_i[SBITS-1]}}, ps_if.revis_i};
    assign im_sx = {{(ACCUM-SBITS){ps_if.imvis_i[SBITS-1]}}, ps_if.imvis_i};

    // first_i re-aligns the current beat to the start of a frame.
    always_comb begin
        beat_addr  = addr_q;
        beat_blk   = blk_q;
        addr_d     = addr_q;
        blk_d      = blk_q;
        sync_err_d = sync_err_q;
        if (ps_if.valid_i) begin
            if (ps_if.first_i) begin
                beat_addr = '0;
                beat_blk  = '0;
                if ((addr_q != '0) || (blk_q != '0)) sync_err_d = 1'b1;
            end
            if (beat_addr == ADDR_LAST) begin
                addr_d = '0;
                blk_d  = (beat_blk == BLK_LAST) ? '0 : beat_blk + BW'(1);
            end else begin
                addr_d = beat_addr + AW'(1);
            end
        end
    end

    acc_sram #(
        .DEPTH (TOTAL),
        .AW    (AW),
        .DW    (2*ACCUM)
    ) u_sram (
        .vis_clock (vis_clock),
        .we_i      (we),
        .waddr_i   (a0_q),
        .wdata_i   ({sum_im, sum_re}),
        .re_i      (ps_if.valid_i),
        .raddr_i   (beat_addr),
        .rdata_o   (rdata)
    );

    assign rd_re = rdata[ACCUM-1:0];
    assign rd_im = rdata[2*ACCUM-1:ACCUM];

    // Block 0 ignores the store, so stale contents never leak into a frame.
    assign sum_re = (z0_q ? '0 : rd_re) + re0_q;
    assign sum_im = (z0_q ? '0 : rd_im) + im0_q;

    assign fire = v0_q && e0_q;
    assign we   = v0_q && !e0_q;

    always_ff @(posedge vis_clock) begin
        if (!reset_n) begin
            addr_q     <= '0;
            blk_q      <= '0;
            sync_err_q <= 1'b0;
            v0_q       <= 1'b0;
            z0_q       <= 1'b0;
            e0_q       <= 1'b0;
            a0_q       <= '0;
            re0_q      <= '0;
            im0_q      <= '0;
            vo_q       <= 1'b0;
            lo_q       <= 1'b0;
            fr_q       <= 1'b0;
            reo_q      <= '0;
            imo_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            blk_q      <= blk_d;
            sync_err_q <= sync_err_d;
            v0_q       <= ps_if.valid_i;
            if (ps_if.valid_i) begin
                a0_q  <= beat_addr;
                z0_q  <= (beat_blk == '0);
                e0_q  <= (beat_blk == BLK_LAST);
                re0_q <= re_sx;
                im0_q <= im_sx;
            end
            vo_q <= fire;
            lo_q <= fire && (a0_q == ADDR_LAST);
            fr_q <= fire && (a0_q == ADDR_LAST);
            if (fire) begin
                reo_q <= sum_re;
                imo_q <= sum_im;
            end
        end
    end

    assign ps_if.valid_o    = vo_q;
    assign ps_if.last_o     = lo_q;
    assign ps_if.frame_o    = fr_q;
    assign ps_if.revis_o    = reo_q;
    assign ps_if.imvis_o    = imo_q;
    assign ps_if.sync_err_o = sync_err_q;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Directed bench for partial_sum_accumulator with TOTAL=4 and
// NBLOCKS of 3, 2 and 1 sharing one input stream.
module tb_partial_sum_accumulator;

    localparam int SB = 7;
    localparam int AC = 36;

    typedef struct {
        int            cyc;
        logic          last;
        logic          frame;
        logic [AC-1:0] re;
        logic [AC-1:0] im;
    } rec_t;

    logic          vis_clock = 1'b0;
    logic          reset_n   = 1'b0;
    logic          valid     = 1'b0;
    logic          first     = 1'b0;
    logic [SB-1:0] re_in     = '0;
    logic [SB-1:0] im_in     = '0;

    int cyc      = 0;
    int checks   = 0;
    int errors   = 0;
    int last_cyc = 0;

    rec_t q3[$];
    rec_t q2[$];
    rec_t q1[$];

    always #5 vis_clock = ~vis_clock;
    always @(posedge vis_clock) cyc <= cyc + 1;

    partial_sum_accumulator_if #(.IN_W(SB), .OUT_W(AC)) if3 ();
    partial_sum_accumulator_if #(.IN_W(SB), .OUT_W(AC)) if2 ();
    partial_sum_accumulator_if #(.IN_W(SB), .OUT_W(AC)) if1 ();

    assign if3.valid_i = valid;
    assign if3.first_i = first;
    assign if3.revis_i = re_in;
    assign if3.imvis_i = im_in;
    assign if2.valid_i = valid;
    assign if2.first_i = first;
    assign if2.revis_i = re_in;
    assign if2.imvis_i = im_in;
    assign if1.valid_i = valid;
    assign if1.first_i = first;
    assign if1.revis_i = re_in;
    assign if1.imvis_i = im_in;

    partial_sum_accumulator #(
        .CORES(2), .TRATE(2), .SBITS(SB), .ACCUM(AC), .NBLOCKS(3)
    ) u_n3 (
        .vis_clock (vis_clock),
        .reset_n   (reset_n),
        .ps_if     (if3)
    );

    partial_sum_accumulator #(
        .CORES(2), .TRATE(2), .SBITS(SB), .ACCUM(AC), .NBLOCKS(2)
    ) u_n2 (
        .vis_clock (vis_clock),
        .reset_n   (reset_n),
        .ps_if     (if2)
    );

    partial_sum_accumulator #(
        .CORES(2), .TRATE(2), .SBITS(SB), .ACCUM(AC), .NBLOCKS(1)
    ) u_n1 (
        .vis_clock (vis_clock),
        .reset_n   (reset_n),
        .ps_if     (if1)
    );

    // Output record carries the cycle number in which valid_o is seen.
    always @(negedge vis_clock) begin
        rec_t r;
        if (if3.valid_o === 1'b1) begin
            r.cyc = cyc + 1; r.last = if3.last_o; r.frame = if3.frame_o;
            r.re = if3.revis_o; r.im = if3.imvis_o;
            q3.push_back(r);
        end
        if (if2.valid_o === 1'b1) begin
            r.cyc = cyc + 1; r.last = if2.last_o; r.frame = if2.frame_o;
            r.re = if2.revis_o; r.im = if2.imvis_o;
            q2.push_back(r);
        end
        if (if1.valid_o === 1'b1) begin
            r.cyc = cyc + 1; r.last = if1.last_o; r.frame = if1.frame_o;
            r.re = if1.revis_o; r.im = if1.imvis_o;
            q1.push_back(r);
        end
    end

    function automatic logic [AC-1:0] x36(input int v);
        x36 = {{(AC-32){v[31]}}, v};
    endfunction

    task automatic beat(input logic v, input logic f, input int re, input int im);
        @(negedge vis_clock);
        valid    = v;
        first    = f;
        re_in    = SB'(re);
        im_in    = SB'(im);
        last_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge vis_clock);
        reset_n = 1'b0;
        valid   = 1'b0;
        first   = 1'b0;
        @(negedge vis_clock);
        @(negedge vis_clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (if3.valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", if3.valid_o);
        end
        checks++;
        if (if3.last_o !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b want 0", if3.last_o);
        end
        checks++;
        if (if3.frame_o !== 1'b0) begin
            errors++; $display("FAIL reset_frame: got %b want 0", if3.frame_o);
        end
        checks++;
        if (if3.sync_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_sync_err: got %b want 0", if3.sync_err_o);
        end
        checks++;
        if (if3.revis_o !== '0) begin
            errors++; $display("FAIL reset_revis: got %h want 0", if3.revis_o);
        end
        checks++;
        if (if3.imvis_o !== '0) begin
            errors++; $display("FAIL reset_imvis: got %h want 0", if3.imvis_o);
        end
    endtask

    task automatic test_basic();
        int in9;
        do_reset();
        q3.delete();
        in9 = 0;
        for (int i = 0; i < 12; i++) begin
            beat(1'b1, i == 0, 1, -1);
            if (i == 8) in9 = last_cyc;
        end
        idle(4);
        checks++;
        if (q3.size() !== 4) begin
            errors++; $display("FAIL basic_count: got %0d want 4", q3.size());
        end
        for (int k = 0; k < q3.size() && k < 4; k++) begin
            checks++;
            if (q3[k].re !== x36(3)) begin
                errors++; $display("FAIL basic_re[%0d]: got %h want %h", k, q3[k].re, x36(3));
            end
            checks++;
            if (q3[k].im !== x36(-3)) begin
                errors++; $display("FAIL basic_im[%0d]: got %h want %h", k, q3[k].im, x36(-3));
            end
            checks++;
            if (q3[k].last !== (k == 3) || q3[k].frame !== (k == 3)) begin
                errors++;
                $display("FAIL basic_last_frame[%0d]: got %b/%b want %b", k,
                         q3[k].last, q3[k].frame, k == 3);
            end
            checks++;
            if (q3[k].cyc !== in9 + 2 + k) begin
                errors++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", k, q3[k].cyc, in9 + 2 + k);
            end
        end
    endtask

    task automatic test_min_value();
        do_reset();
        q2.delete();
        for (int i = 0; i < 32; i++) beat(1'b1, i == 0, -64, 63);
        idle(4);
        checks++;
        if (q2.size() !== 16) begin
            errors++; $display("FAIL min_count: got %0d want 16", q2.size());
        end
        for (int k = 0; k < q2.size() && k < 16; k++) begin
            checks++;
            if (q2[k].re !== x36(-128)) begin
                errors++; $display("FAIL min_re[%0d]: got %h want %h", k, q2[k].re, x36(-128));
            end
            checks++;
            if (q2[k].im !== x36(126)) begin
                errors++; $display("FAIL min_im[%0d]: got %h want %h", k, q2[k].im, x36(126));
            end
            checks++;
            if (q2[k].last !== (k % 4 == 3)) begin
                errors++; $display("FAIL min_last[%0d]: got %b want %b", k, q2[k].last, k % 4 == 3);
            end
        end
    endtask

    function automatic int rv(input int j);
        return ((j * 37 + 5) % 128) - 64;
    endfunction

    function automatic int iv(input int j);
        return 63 - ((j * 23) % 128);
    endfunction

    task automatic test_gaps();
        int er;
        int ei;
        do_reset();
        q2.delete();
        for (int j = 0; j < 16; j++) begin
            beat(1'b1, j == 0, rv(j), iv(j));
            if (j % 3 == 1) idle(1);
        end
        idle(4);
        checks++;
        if (q2.size() !== 8) begin
            errors++; $display("FAIL gaps_count: got %0d want 8", q2.size());
        end
        for (int k = 0; k < q2.size() && k < 8; k++) begin
            er = rv((k / 4) * 8 + (k % 4)) + rv((k / 4) * 8 + 4 + (k % 4));
            ei = iv((k / 4) * 8 + (k % 4)) + iv((k / 4) * 8 + 4 + (k % 4));
            checks++;
            if (q2[k].re !== x36(er) || q2[k].im !== x36(ei)) begin
                errors++;
                $display("FAIL gaps_data[%0d]: got %h/%h want %h/%h", k,
                         q2[k].re, q2[k].im, x36(er), x36(ei));
            end
            checks++;
            if (q2[k].last !== (k % 4 == 3)) begin
                errors++; $display("FAIL gaps_last[%0d]: got %b want %b", k, q2[k].last, k % 4 == 3);
            end
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        q3.delete();
        beat(1'b1, 1'b1, 9, 9);
        beat(1'b1, 1'b0, 9, 9);
        for (int i = 0; i < 12; i++) begin
            beat(1'b1, i == 0, 2, 1);
            if (i == 0) begin
                checks++;
                if (if3.sync_err_o !== 1'b0) begin
                    errors++; $display("FAIL sync_err_early: got %b want 0", if3.sync_err_o);
                end
            end
            if (i == 1) begin
                checks++;
                if (if3.sync_err_o !== 1'b1) begin
                    errors++; $display("FAIL sync_err_set: got %b want 1", if3.sync_err_o);
                end
            end
        end
        idle(4);
        checks++;
        if (if3.sync_err_o !== 1'b1) begin
            errors++; $display("FAIL sync_err_sticky: got %b want 1", if3.sync_err_o);
        end
        checks++;
        if (q3.size() !== 4) begin
            errors++; $display("FAIL sync_count: got %0d want 4", q3.size());
        end
        for (int k = 0; k < q3.size() && k < 4; k++) begin
            checks++;
            if (q3[k].re !== x36(6) || q3[k].im !== x36(3)) begin
                errors++;
                $display("FAIL sync_data[%0d]: got %h/%h want %h/%h", k,
                         q3[k].re, q3[k].im, x36(6), x36(3));
            end
        end
    endtask

    task automatic test_reset_mid();
        q3.delete();
        for (int i = 0; i < 6; i++) beat(1'b1, i == 0, 7, 7);
        @(negedge vis_clock);
        reset_n = 1'b0;
        valid   = 1'b0;
        first   = 1'b0;
        @(negedge vis_clock);
        reset_n = 1'b1;
        checks++;
        if (if3.valid_o !== 1'b0 || if3.revis_o !== '0 || if3.imvis_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_during: got v=%b re=%h im=%h want 0", if3.valid_o,
                     if3.revis_o, if3.imvis_o);
        end
        checks++;
        if (if3.sync_err_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_sync_err: got %b want 0", if3.sync_err_o);
        end
        idle(3);
        checks++;
        if (if3.valid_o !== 1'b0 || if3.revis_o !== '0 || q3.size() !== 0) begin
            errors++;
            $display("FAIL rst_mid_after: got v=%b re=%h n=%0d want 0", if3.valid_o,
                     if3.revis_o, q3.size());
        end
        for (int i = 0; i < 12; i++) beat(1'b1, i == 0, -3, 4);
        idle(4);
        checks++;
        if (q3.size() !== 4) begin
            errors++; $display("FAIL rst_mid_count: got %0d want 4", q3.size());
        end
        for (int k = 0; k < q3.size() && k < 4; k++) begin
            checks++;
            if (q3[k].re !== x36(-9) || q3[k].im !== x36(12)) begin
                errors++;
                $display("FAIL rst_mid_data[%0d]: got %h/%h want %h/%h", k,
                         q3[k].re, q3[k].im, x36(-9), x36(12));
            end
        end
    endtask

    task automatic test_single_block();
        int in0;
        int ere[8];
        int eim[8];
        ere = '{5, 1, 2, 3, 10, 11, 12, 13};
        eim = '{-2, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        q1.delete();
        in0 = 0;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, (i % 4) == 0, ere[i], eim[i]);
            if (i == 0) in0 = last_cyc;
        end
        idle(4);
        checks++;
        if (if1.sync_err_o !== 1'b0) begin
            errors++; $display("FAIL single_sync_err: got %b want 0", if1.sync_err_o);
        end
        checks++;
        if (q1.size() !== 8) begin
            errors++; $display("FAIL single_count: got %0d want 8", q1.size());
        end
        for (int k = 0; k < q1.size() && k < 8; k++) begin
            checks++;
            if (q1[k].re !== x36(ere[k]) || q1[k].im !== x36(eim[k])) begin
                errors++;
                $display("FAIL single_data[%0d]: got %h/%h want %h/%h", k,
                         q1[k].re, q1[k].im, x36(ere[k]), x36(eim[k]));
            end
            checks++;
            if (q1[k].cyc !== in0 + 2 + k) begin
                errors++; $display("FAIL single_cycle[%0d]: got %0d want %0d", k, q1[k].cyc, in0 + 2 + k);
            end
            checks++;
            if (q1[k].frame !== (k % 4 == 3) || q1[k].last !== (k % 4 == 3)) begin
                errors++;
                $display("FAIL single_frame[%0d]: got %b/%b want %b", k,
                         q1[k].frame, q1[k].last, k % 4 == 3);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_min_value();
        test_gaps();
        test_sync_err();
        test_reset_mid();
        test_single_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/partial_sum_accumulator.md
Name: partial_sum_accumulator

Overview:
- Sits directly downstream of the daisy-chained correlator array, in the vis_clock domain.
- Consumes one stream of signed partial-sum visibilities (re/im), TOTAL = CORES*TRATE values per block.
- Accumulates NBLOCKS consecutive blocks per visibility, point by point, in a read-modify-write SRAM.
- On the final block it emits full-width visibilities to the output-bank writer.

Parameters:
- CORES, 18, number of correlator cores.
- TRATE, 30, time-multiplexing rate; TOTAL = CORES*TRATE visibilities per block (TOTAL >= 2 required).
- SBITS, 7, width of signed partial-sum inputs.
- ACCUM, 36, width of signed accumulators and outputs.
- NBLOCKS, 4096, partial-sum blocks per output frame (>= 1).

Ports:
- vis_clock, in, 1, processing clock.
- reset_n, in, 1, reset.
- valid_i, in, 1, partial-sum beat valid; no backpressure.
- first_i, in, 1, qualified by valid_i; marks beat 0 of block 0 of a frame (resync).
- revis_i, in, SBITS, signed real partial sum.
- imvis_i, in, SBITS, signed imaginary partial sum.
- valid_o, out, 1, completed visibility valid.
- last_o, out, 1, qualifies the final visibility (index TOTAL-1) of a frame.
- revis_o, out, ACCUM, accumulated real visibility.
- imvis_o, out, ACCUM, accumulated imaginary visibility.
- frame_o, out, 1, one-cycle pulse coincident with valid_o && last_o.
- sync_err_o, out, 1, sticky: first_i seen with addr != 0 or blk != 0.

Interface: reset reset_n, synchronous, active-low; clock vis_clock.

Behaviour:
- Reset: valid_o, last_o, frame_o and sync_err_o = 0; revis_o and imvis_o = 0; addr = 0; blk = 0; pipeline valids = 0. SRAM contents are not cleared.
- Counters:
  - addr counts 0..TOTAL-1 on each valid_i and wraps to 0.
  - On the wrap, blk increments, wrapping from NBLOCKS-1 to 0.
  - valid_i && first_i forces the beat to addr = 0, blk = 0; counters continue from there.
  - If addr or blk was nonzero when first_i arrived, set sync_err_o (cleared only by reset).
- Pipeline, 2 stages:
  - S0 (input cycle): issue SRAM read at addr; register the sign-extended inputs, addr, the zero flag (blk == 0) and the emit flag (blk == NBLOCKS-1).
  - S1: sum = (zero ? 0 : sram_rdata) + sext(input). Write sum back to addr unless emit.
  - On emit, drive registered outputs with sum the next cycle; last_o = (addr == TOTAL-1).
- Latency: valid_i at cycle n gives valid_o at cycle n+2. Throughput: one beat per cycle with arbitrary gaps.
- NBLOCKS == 1: zero and emit are both true; the output equals the sign-extended input.
- Hazards: consecutive beats always hit distinct addresses (TOTAL >= 2), so there is no RAW forwarding. The S1 write to TOTAL-1 coincides with the S0 read of 0, which is legal on the separate write and read ports.
- Arithmetic: two's complement with sign extension from SBITS to ACCUM. Overflow wraps modulo 2^ACCUM with no saturation; ACCUM must cover NBLOCKS*2^(SBITS-1).
- valid_i low: the pipeline holds its counters and valid_o = 0 next-but-one. The output data regs hold their last values.
- Reset mid-frame: all in-flight beats are dropped. The next frame must start with first_i; stale SRAM data is never used because blk 0 bypasses the read.

Decomposition:
- Shared package tart_corr_pkg holds CORES, TRATE, TOTAL, SBITS, ACCUM, and the address width $clog2(TOTAL) and block-counter width $clog2(NBLOCKS).
- One sub-module, acc_sram: simple dual-port, 1 write / 1 read, synchronous read with 1-cycle latency, TOTAL x 2*ACCUM bits. Imag and real are packed in one word.

Test Plan:
- NBLOCKS=3, TOTAL=4, all inputs re=+1, im=-1, three blocks back-to-back with first_i on beat 0 -> exactly 4 valid_o beats starting 2 cycles after the 9th input. Each output is re=3, im=-3; last_o and frame_o are high on the 4th beat only.
- NBLOCKS=2, re_i=-64 (min 7-bit) on every beat for 4 frames -> each output re = -128, sign-extended correctly to 36 bits; the second frame shows no carry-over from the first (blk-0 bypass).
- NBLOCKS=2, random 1-in-3 valid_i gaps, reference model on inputs -> outputs match the model in order, valid_o count = TOTAL per frame.
- first_i asserted at addr=2 mid-block -> sync_err_o = 1 next cycle and stays high. The accumulation restarts at addr=0, blk=0, and the next complete frame has correct sums.
- reset_n low for 1 cycle during block 1 of 3, then a clean frame -> all outputs are 0 during and after reset until the new frame emits; the emitted values exclude pre-reset data.
- NBLOCKS=1, input re=5 at index 0 -> valid_o at n+2 with revis_o=5; frame_o pulses on the TOTAL-1 beat.
